adcfifo_stream_sched: RTL and testbench
=======================================

Name: adcfifo_stream_sched

Overview:
Arbiter/sequencer for the ADC sample FIFO read port. The port is shared between two consumers:
- the USB register-read path: single-byte pops on request;
- a streaming engine: drains fixed-size segments over a valid/ready interface.

Ownership switches only at segment boundaries, so byte order within a segment is never interleaved. The block sits between the ADC FIFO (first-word-fall-through) and the USB register/streaming front end.

Parameters:
pSTALL_W, 16, width of the stream stall counter.
pSTALL_LIMIT, 1000, consecutive empty cycles in STREAM before stall_err sets (must be less than 2^pSTALL_W).

Ports:
clk_usb  in  1  clock.
reset_i  in  1  reset; synchronous, active-high.
fifo_empty  in  1  FIFO empty; fifo_data is valid when low (FWFT).
fifo_data  in  8  FIFO head byte.
fifo_rd_en  out  1  pop strobe; never high while fifo_empty.
reg_rd_req  in  1  one-cycle request for a single register-path byte.
reg_data  out  8  byte returned to the register path.
reg_data_valid  out  1  one-cycle strobe qualifying reg_data.
reg_underrun  out  1  sticky; a register read found the FIFO empty.
stream_enable  in  1  level; enables segment streaming.
segment_size  in  32  bytes per segment; sampled at segment start.
stream_data  out  8  stream byte.
stream_valid  out  1  stream byte available.
stream_ready  in  1  downstream accept.
segment_done  out  1  one-cycle pulse after the last byte of a segment is popped.
bytes_sent  out  32  stream bytes popped since the last IDLE->STREAM transition.
stall_err  out  1  sticky stream-stall flag.
clear_errors  in  1  clears reg_underrun and stall_err.
busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values: all outputs 0; state IDLE; reg_pending, seg_cnt, stall_cnt, seg_len all 0.

reg_pending:
- Set by reg_rd_req; cleared when the request is served.
- A reg_rd_req arriving while a request is already pending is dropped (one outstanding request max).

States: IDLE, STREAM, SEG_GAP, REG.

IDLE:
- If reg_pending: go to REG (register wins over stream start).
- Else if stream_enable: go to STREAM; latch seg_len = segment_size (0 is treated as 1); clear seg_cnt and bytes_sent.

STREAM:
- stream_valid = ~fifo_empty; stream_data = fifo_data (combinational).
- fifo_rd_en = stream_valid & stream_ready.
- On each pop: seg_cnt++ and bytes_sent++ (bytes_sent wraps modulo 2^32).
- On the pop with seg_cnt == seg_len-1: go to SEG_GAP, with segment_done high the following cycle.
- reg_rd_req during STREAM stays pending until SEG_GAP.
- stream_enable deassertion mid-segment does not abort; the segment completes.

SEG_GAP (exactly one cycle; segment_done = 1):
- If reg_pending: go to REG.
- Else if stream_enable: go to STREAM; re-latch seg_len; clear seg_cnt; bytes_sent is NOT cleared.
- Else: go to IDLE.

REG (one cycle):
- If ~fifo_empty: fifo_rd_en = 1 and fifo_data is captured into reg_data.
- If fifo_empty: no pop, reg_data = 0x00, and reg_underrun sets.
- reg_data_valid pulses the next cycle in both cases.
- Clear reg_pending.
- Next state: STREAM (new segment, seg_len re-latched) if stream_enable, else IDLE.
- At most one register read is served per segment gap. Register reads are served back-to-back while in IDLE.

Latency: reg_rd_req at cycle N (IDLE) -> REG at N+1 -> reg_data_valid at N+2.

Stall detection:
- In STREAM, stall_cnt increments (saturating) each cycle with fifo_empty, and clears on any non-empty cycle.
- stall_cnt reaching pSTALL_LIMIT sets stall_err.
- stall_cnt is held at 0 outside STREAM.

Error flags: when clear_errors and a set event occur in the same cycle, the set wins.

Reset mid-operation: everything returns to reset values next edge; no pop occurs in the reset cycle.

busy is high in STREAM, SEG_GAP and REG.

Decomposition:
- Shared package/includes: state encoding constants (IDLE=0, STREAM=1, SEG_GAP=2, REG=3) and the segment_size==0 -> 1 rule constant.
- No sub-module needed. Optional natural split: adcfifo_seg_counter, holding seg_cnt, seg_len and the last-byte compare.

Test Plan:
1. Reset; stream_enable=1, segment_size=4, FIFO holds 10 bytes 0x00..0x09, ready=1 -> bytes 00-03 streamed, segment_done pulse, 04-07 streamed, then 08,09 and stall; bytes_sent=10.
2. IDLE, FIFO = {0xA5}, reg_rd_req at N -> fifo_rd_en at N+1; reg_data=0xA5 with reg_data_valid at N+2.
3. Mid-segment (seg_cnt=1 of 4) reg_rd_req -> no pop for the register until after the 4th stream byte. SEG_GAP then REG pops byte 4 to reg_data; streaming resumes with byte 5.
4. segment_size=0, 3 bytes queued -> segment_done after every byte (3 pulses).
5. STREAM with FIFO empty and pSTALL_LIMIT=8 -> stall_err rises after 8 empty cycles. clear_errors asserted in the set cycle keeps it 1. clear_errors alone clears it.
6. Empty FIFO, reg_rd_req -> reg_data=0x00, reg_data_valid pulse, reg_underrun=1, fifo_rd_en never high. Assert reset_i mid-STREAM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/adcfifo_stream_sched_pkg.sv
// Shared types and constants for the ADC FIFO read-port scheduler.
package adcfifo_stream_sched_pkg;

    // Read-port ownership states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_SEG_GAP = 2'd2,
        ST_REG     = 2'd3
    } sched_state_e;

    // A requested segment size of zero is promoted to this length
    localparam logic [31:0] SEG_LEN_MIN = 32'd1;

    // Effective segment length for a requested size
    function automatic logic [31:0] seg_len_of(input logic [31:0] size);
        return (size == 32'd0) ? SEG_LEN_MIN : size;
    endfunction

endpackage

// File: rtl/adcfifo_stream_sched_if.sv
// FIFO, register-path and streaming signals of the read-port scheduler.
interface adcfifo_stream_sched_if;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        reg_rd_req;
    logic [7:0]  reg_data;
    logic        reg_data_valid;
    logic        reg_underrun;
    logic        stream_enable;
    logic [31:0] segment_size;
    logic [7:0]  stream_data;
    logic        stream_valid;
    logic        stream_ready;
    logic        segment_done;
    logic [31:0] bytes_sent;
    logic        stall_err;
    logic        clear_errors;
    logic        busy;

    // Scheduler side
    modport slave (
        input  fifo_empty, fifo_data, reg_rd_req, stream_enable, segment_size,
               stream_ready, clear_errors,
        output fifo_rd_en, reg_data, reg_data_valid, reg_underrun, stream_data,
               stream_valid, segment_done, bytes_sent, stall_err, busy
    );

    // FIFO / USB front-end side
    modport master (
        output fifo_empty, fifo_data, reg_rd_req, stream_enable, segment_size,
               stream_ready, clear_errors,
        input  fifo_rd_en, reg_data, reg_data_valid, reg_underrun, stream_data,
               stream_valid, segment_done, bytes_sent, stall_err, busy
    );
endinterface

// File: rtl/adcfifo_stream_sched_seg_counter.sv
// Segment byte counter: latches the segment length at segment start and
// flags when the next stream pop is the last byte of the segment.
module adcfifo_stream_sched_seg_counter
    import adcfifo_stream_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] size_i,
    input  logic        pop_i,
    output logic        last_o
);
    logic [31:0] seg_cnt_d, seg_cnt_q;
    logic [31:0] seg_len_d, seg_len_q;

    // Restart on a new segment, otherwise count stream pops
    always_comb begin
        seg_cnt_d = seg_cnt_q;
        seg_len_d = seg_len_q;
        if (start_i) begin
            seg_cnt_d = 32'd0;
            seg_len_d = seg_len_of(size_i);
        end else if (pop_i) begin
            seg_cnt_d = seg_cnt_q + 32'd1;
        end else begin
            seg_cnt_d = seg_cnt_q;
        end
    end

    // Counter and length registers
    always_ff @(posedge clk) begin
        if (reset_i) begin
            seg_cnt_q <= 32'd0;
            seg_len_q <= 32'd0;
        end else begin
            seg_cnt_q <= seg_cnt_d;
            seg_len_q <= seg_len_d;
        end
    end

    assign last_o = (seg_cnt_q == (seg_len_q - 32'd1));

endmodule

// File: rtl/adcfifo_stream_sched.sv
// ADC FIFO read-port scheduler: shares the FWFT FIFO between single-byte
// register reads and segment streaming, switching owner only between segments.
module adcfifo_stream_sched
    import adcfifo_stream_sched_pkg::*;
#(
    parameter int unsigned pSTALL_W     = 16,
    parameter int unsigned pSTALL_LIMIT = 1000
) (
    input  logic                   clk_usb,
    input  logic                   reset_i,
    adcfifo_stream_sched_if.slave  bus
);
    localparam logic [pSTALL_W-1:0] STALL_ONE    = pSTALL_W'(1);
    localparam logic [pSTALL_W-1:0] STALL_MAX    = {pSTALL_W{1'b1}};
    localparam logic [pSTALL_W-1:0] STALL_SET_AT = pSTALL_W'(pSTALL_LIMIT - 1);

    sched_state_e        state_d, state_q;
    logic                reg_pending_d, reg_pending_q;
    logic [pSTALL_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [31:0]         bytes_sent_d, bytes_sent_q;
    logic [7:0]          reg_data_d, reg_data_q;
    logic                reg_data_valid_d, reg_data_valid_q;
    logic                reg_underrun_d, reg_underrun_q;
    logic                segment_done_d, segment_done_q;
    logic                stall_err_d, stall_err_q;

    logic req_s, seg_start_s, seg_last_s, stall_set_s;
    logic stream_act_s, stream_valid_s, stream_pop_s, reg_serve_s, reg_pop_s;

    // Nothing is popped in a reset cycle, whatever the current state
    assign req_s          = reg_pending_q | bus.reg_rd_req;
    assign stream_act_s   = (state_q == ST_STREAM) & ~reset_i;
    assign stream_valid_s = stream_act_s & ~bus.fifo_empty;
    assign stream_pop_s   = stream_valid_s & bus.stream_ready;
    assign reg_serve_s    = (state_q == ST_REG) & ~reset_i;
    assign reg_pop_s      = reg_serve_s & ~bus.fifo_empty;
    assign stall_set_s    = stream_act_s & bus.fifo_empty & (stall_cnt_q == STALL_SET_AT);

    adcfifo_stream_sched_seg_counter u_seg_counter (
        .clk     (clk_usb),
        .reset_i (reset_i),
        .start_i (seg_start_s),
        .size_i  (bus.segment_size),
        .pop_i   (stream_pop_s),
        .last_o  (seg_last_s)
    );

    // Next-state decode; register reads win at IDLE and at segment gaps
    always_comb begin
        state_d     = state_q;
        seg_start_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_SEG_GAP: begin
                if (req_s) begin
                    state_d = ST_REG;
                end else if (bus.stream_enable) begin
                    state_d     = ST_STREAM;
                    seg_start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (stream_pop_s && seg_last_s) begin
                    state_d = ST_SEG_GAP;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_REG: begin
                if (bus.stream_enable) begin
                    state_d     = ST_STREAM;
                    seg_start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath, counters and sticky flags; error set wins over clear
    always_comb begin
        reg_pending_d    = (state_q == ST_REG) ? 1'b0 : req_s;
        reg_data_valid_d = reg_serve_s;
        segment_done_d   = stream_pop_s & seg_last_s;
        reg_underrun_d   = (reg_serve_s & bus.fifo_empty) | (reg_underrun_q & ~bus.clear_errors);
        stall_err_d      = stall_set_s | (stall_err_q & ~bus.clear_errors);

        if (reg_serve_s) begin
            reg_data_d = bus.fifo_empty ? 8'h00 : bus.fifo_data;
        end else begin
            reg_data_d = reg_data_q;
        end

        if (seg_start_s && (state_q == ST_IDLE)) begin
            bytes_sent_d = 32'd0;
        end else if (stream_pop_s) begin
            bytes_sent_d = bytes_sent_q + 32'd1;
        end else begin
            bytes_sent_d = bytes_sent_q;
        end

        if (!stream_act_s || !bus.fifo_empty) begin
            stall_cnt_d = {pSTALL_W{1'b0}};
        end else if (stall_cnt_q == STALL_MAX) begin
            stall_cnt_d = STALL_MAX;
        end else begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end
    end

    // State and output registers
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            reg_pending_q    <= 1'b0;
            stall_cnt_q      <= {pSTALL_W{1'b0}};
            bytes_sent_q     <= 32'd0;
            reg_data_q       <= 8'h00;
            reg_data_valid_q <= 1'b0;
            reg_underrun_q   <= 1'b0;
            segment_done_q   <= 1'b0;
            stall_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            reg_pending_q    <= reg_pending_d;
            stall_cnt_q      <= stall_cnt_d;
            bytes_sent_q     <= bytes_sent_d;
            reg_data_q       <= reg_data_d;
            reg_data_valid_q <= reg_data_valid_d;
            reg_underrun_q   <= reg_underrun_d;
            segment_done_q   <= segment_done_d;
            stall_err_q      <= stall_err_d;
        end
    end

    assign bus.fifo_rd_en     = stream_pop_s | reg_pop_s;
    assign bus.stream_valid   = stream_valid_s;
    assign bus.stream_data    = stream_valid_s ? bus.fifo_data : 8'h00;
    assign bus.reg_data       = reg_data_q;
    assign bus.reg_data_valid = reg_data_valid_q;
    assign bus.reg_underrun   = reg_underrun_q;
    assign bus.segment_done   = segment_done_q;
    assign bus.bytes_sent     = bytes_sent_q;
    assign bus.stall_err      = stall_err_q;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adcfifo_stream_sched.sv
// Bench for adcfifo_stream_sched: directed scenarios plus randomized traffic
// checked against a transaction-level model of the shared FIFO read port.
module tb_adcfifo_stream_sched;

    logic clk_usb = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk_usb = ~clk_usb;

    adcfifo_stream_sched_if bus ();

    adcfifo_stream_sched #(.pSTALL_W(16), .pSTALL_LIMIT(8)) dut (
        .clk_usb (clk_usb),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  q[$];
    logic [7:0]  got_stream[$];
    int          done_cnt;
    int          first_done_cyc;
    int          seg_pops;
    logic        outstanding;
    logic        prev_reg_pop;
    logic [7:0]  prev_reg_byte;
    logic [31:0] exp_sent;
    logic        rd_seen;
    logic        rst_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_data  = (q.size() == 0) ? 8'hEE : q[0];
    endtask

    // Per-cycle observation: FIFO order, handshakes, register replies, segments
    task automatic mon();
        logic        s_pop;
        logic        r_pop;
        logic [31:0] exp_len;
        rst_seen = reset_i;
        rd_seen  = bus.fifo_rd_en;
        if (reset_i) begin
            check_val("rd_in_reset", 32'(bus.fifo_rd_en), 32'd0);
            return;
        end
        exp_len = (bus.segment_size == 32'd0) ? 32'd1 : bus.segment_size;
        s_pop   = bus.stream_valid & bus.stream_ready;
        r_pop   = bus.fifo_rd_en & ~s_pop;
        if (bus.fifo_rd_en) check_val("rd_when_empty", 32'(bus.fifo_empty), 32'd0);
        if (s_pop) check_val("rd_on_accept", 32'(bus.fifo_rd_en), 32'd1);
        check_val("bytes_sent", bus.bytes_sent, exp_sent);
        if (bus.stream_valid) begin
            check_val("stream_valid_empty", 32'(bus.fifo_empty), 32'd0);
            if (q.size() > 0) check_val("stream_data", 32'(bus.stream_data), 32'(q[0]));
        end
        if (prev_reg_pop) check_val("reg_valid_after_pop", 32'(bus.reg_data_valid), 32'd1);
        if (bus.reg_data_valid) begin
            check_val("reg_valid_requested", 32'(outstanding), 32'd1);
            check_val("reg_data", 32'(bus.reg_data), prev_reg_pop ? 32'(prev_reg_byte) : 32'd0);
            if (!prev_reg_pop) check_val("reg_underrun", 32'(bus.reg_underrun), 32'd1);
            outstanding = 1'b0;
        end
        if (bus.reg_rd_req && !outstanding) outstanding = 1'b1;
        prev_reg_pop = r_pop;
        if (r_pop) begin
            check_val("reg_pop_midseg", 32'(seg_pops), 32'd0);
            check_val("reg_pop_requested", 32'(outstanding), 32'd1);
            prev_reg_byte = (q.size() > 0) ? q[0] : 8'hEE;
        end
        if (s_pop) begin
            check_val("seg_len_bound", 32'(32'(seg_pops) < exp_len), 32'd1);
            got_stream.push_back(bus.stream_data);
            seg_pops++;
            exp_sent++;
        end
        if (bus.segment_done) begin
            check_val("seg_len", 32'(seg_pops), exp_len);
            seg_pops = 0;
            done_cnt++;
            if (first_done_cyc < 0) first_done_cyc = cyc;
        end
    endtask

    task automatic step();
        #1;
        mon();
        @(posedge clk_usb);
        #1;
        if (rst_seen) begin
            seg_pops     = 0;
            outstanding  = 1'b0;
            prev_reg_pop = 1'b0;
            exp_sent     = 32'd0;
        end else if (rd_seen && q.size() > 0) begin
            void'(q.pop_front());
        end
        drive_fifo();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset_i           = 1'b1;
        bus.stream_enable = 1'b0;
        bus.segment_size  = 32'd4;
        bus.stream_ready  = 1'b0;
        bus.reg_rd_req    = 1'b0;
        bus.clear_errors  = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        q.delete();
        drive_fifo();
        got_stream.delete();
        done_cnt       = 0;
        first_done_cyc = -1;
        cyc            = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e3 [9];
        e3 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        q.delete();
        drive_fifo();
        do_reset();

        // Reset state
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_outputs", {24'd0, bus.fifo_rd_en, bus.reg_data_valid, bus.reg_underrun,
                  bus.stream_valid, bus.segment_done, bus.stall_err, 2'b00}, 32'd0);
        check_val("rst_bytes_sent", bus.bytes_sent, 32'd0);

        // Two full segments of 4, then a partial one and starvation
        for (int i = 0; i < 10; i++) q.push_back(8'(i));
        drive_fifo();
        bus.stream_enable = 1'b1;
        bus.stream_ready  = 1'b1;
        repeat (20) step();
        check_val("t1_count", 32'(got_stream.size()), 32'd10);
        for (int i = 0; i < 10 && i < got_stream.size(); i++)
            check_val("t1_byte", 32'(got_stream[i]), 32'(i));
        check_val("t1_done_cnt", 32'(done_cnt), 32'd2);
        check_val("t1_done_cyc", 32'(first_done_cyc), 32'd5);
        check_val("t1_bytes_sent", bus.bytes_sent, 32'd10);
        check_val("t1_busy", 32'(bus.busy), 32'd1);

        // Register read from IDLE: pop at N+1, data at N+2
        do_reset();
        q.push_back(8'hA5);
        drive_fifo();
        bus.reg_rd_req = 1'b1;
        step();
        bus.reg_rd_req = 1'b0;
        check_val("t2_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        check_val("t2_busy", 32'(bus.busy), 32'd1);
        check_val("t2_early_valid", 32'(bus.reg_data_valid), 32'd0);
        step();
        check_val("t2_valid", 32'(bus.reg_data_valid), 32'd1);
        check_val("t2_data", 32'(bus.reg_data), 32'h0000_00A5);
        check_val("t2_idle", 32'(bus.busy), 32'd0);
        check_val("t2_no_underrun", 32'(bus.reg_underrun), 32'd0);
        step();
        check_val("t2_valid_pulse", 32'(bus.reg_data_valid), 32'd0);

        // Register request mid-segment waits for the segment gap
        do_reset();
        for (int i = 0; i < 10; i++) q.push_back(8'(i));
        drive_fifo();
        bus.stream_enable = 1'b1;
        bus.stream_ready  = 1'b1;
        step();
        step();
        bus.reg_rd_req = 1'b1;
        step();
        bus.reg_rd_req = 1'b0;
        step();
        step();
        check_val("t3_gap", 32'(bus.segment_done), 32'd1);
        step();
        check_val("t3_reg_pop", 32'(bus.fifo_rd_en), 32'd1);
        check_val("t3_no_stream", 32'(bus.stream_valid), 32'd0);
        step();
        check_val("t3_valid", 32'(bus.reg_data_valid), 32'd1);
        check_val("t3_data", 32'(bus.reg_data), 32'h0000_0004);
        repeat (7) step();
        check_val("t3_count", 32'(got_stream.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_stream.size(); i++)
            check_val("t3_byte", 32'(got_stream[i]), 32'(e3[i]));

        // segment_size 0 behaves as 1
        do_reset();
        q.push_back(8'h10);
        q.push_back(8'h11);
        q.push_back(8'h12);
        drive_fifo();
        bus.segment_size  = 32'd0;
        bus.stream_enable = 1'b1;
        bus.stream_ready  = 1'b1;
        repeat (10) step();
        check_val("t4_done_cnt", 32'(done_cnt), 32'd3);
        check_val("t4_bytes_sent", bus.bytes_sent, 32'd3);

        // Stall detection, set-beats-clear, then clear alone
        do_reset();
        bus.stream_enable = 1'b1;
        bus.stream_ready  = 1'b1;
        repeat (8) step();
        check_val("t5_not_yet", 32'(bus.stall_err), 32'd0);
        bus.clear_errors = 1'b1;
        step();
        check_val("t5_set_wins", 32'(bus.stall_err), 32'd1);
        step();
        check_val("t5_cleared", 32'(bus.stall_err), 32'd0);
        bus.clear_errors = 1'b0;
        step();
        check_val("t5_stays_clear", 32'(bus.stall_err), 32'd0);

        // Underrun on an empty FIFO, then reset in the middle of streaming
        do_reset();
        bus.reg_rd_req = 1'b1;
        step();
        bus.reg_rd_req = 1'b0;
        check_val("t6_no_pop", 32'(bus.fifo_rd_en), 32'd0);
        step();
        check_val("t6_valid", 32'(bus.reg_data_valid), 32'd1);
        check_val("t6_data", 32'(bus.reg_data), 32'd0);
        check_val("t6_underrun", 32'(bus.reg_underrun), 32'd1);
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h40 + i));
        drive_fifo();
        bus.stream_enable = 1'b1;
        bus.stream_ready  = 1'b1;
        repeat (3) step();
        check_val("t6_streaming", 32'(bus.stream_valid), 32'd1);
        reset_i = 1'b1;
        #1;
        check_val("t6_no_pop_in_reset", 32'(bus.fifo_rd_en), 32'd0);
        step();
        check_val("t6_rst_flags", {24'd0, bus.busy, bus.fifo_rd_en, bus.reg_data_valid,
                  bus.reg_underrun, bus.stream_valid, bus.segment_done, bus.stall_err, 1'b0}, 32'd0);
        check_val("t6_rst_bytes_sent", bus.bytes_sent, 32'd0);
        check_val("t6_rst_data", {16'd0, bus.reg_data, bus.stream_data}, 32'd0);
        reset_i = 1'b0;

        // Randomized traffic against the transaction-level model
        for (int run = 0; run < 3; run++) begin
            do_reset();
            bus.segment_size  = 32'($urandom_range(0, 6));
            bus.stream_enable = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if (q.size() < 24 && $urandom_range(0, 1) == 1) q.push_back(8'($urandom));
                drive_fifo();
                bus.stream_ready = ($urandom_range(0, 3) != 0);
                bus.reg_rd_req   = ($urandom_range(0, 7) == 0);
                bus.clear_errors = ($urandom_range(0, 15) == 0);
                step();
            end
            bus.reg_rd_req   = 1'b0;
            bus.clear_errors = 1'b0;
            bus.stream_ready = 1'b1;
            repeat (20) q.push_back(8'($urandom));
            drive_fifo();
            repeat (40) step();
            check_val("rand_req_served", 32'(outstanding), 32'd0);
            check_val("rand_bytes_sent", bus.bytes_sent, exp_sent);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
